// File: rtl/vx_axi_read_burst_splitter.sv
// AXI4 read burst splitter: cuts long INCR bursts into MAX_BURST_LEN sub-bursts, tags the final one in
// the ID MSB, strips rlast of non-final ones, and caps sub-bursts in flight. Optional R skid buffer: VX_AXI_SPLIT_RSP_BUF_EN.
module vx_axi_read_burst_splitter #(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_TID_WIDTH   = 8,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_TID_WIDTH-1:0]  s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic [1:0]                s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arqos,
  input  logic [3:0]                s_axi_arregion,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic [AXI_TID_WIDTH-1:0]  s_axi_rid,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [AXI_TID_WIDTH:0]    m_axi_arid,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [1:0]                m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic [3:0]                m_axi_arregion,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic [AXI_TID_WIDTH:0]    m_axi_rid
);

  localparam logic [8:0] MAX_LEN = 9'(MAX_BURST_LEN);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                    state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_mask, addr_step;
  logic [AXI_TID_WIDTH-1:0]  id_q;
  logic [8:0]                remaining_q, sub;
  logic [2:0]                size_q, prot_q;
  logic [1:0]                burst_q, lock_q;
  logic [3:0]                cache_q, qos_q, region_q;
  logic [7:0]                outstanding_q;
  logic                      s_ar_hs, m_ar_hs, r_last_hs;

  assign s_axi_arready = (state == IDLE) && reset_n;
  assign m_axi_arvalid = (state == SPLIT) && (outstanding_q < MAX_OUT);
  assign s_ar_hs       = s_axi_arvalid && s_axi_arready;
  assign m_ar_hs       = m_axi_arvalid && m_axi_arready;
  assign r_last_hs     = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_comb begin
    sub = remaining_q;
    if (burst_q == BURST_INCR && remaining_q > MAX_LEN) sub = MAX_LEN;
    addr_mask = '1;
    addr_mask = addr_mask << size_q;
    addr_step = AXI_ADDR_WIDTH'(sub) << size_q;
  end

  assign m_axi_araddr   = addr_q;
  assign m_axi_arid     = {sub == remaining_q, id_q};
  assign m_axi_arlen    = 8'(sub - 9'd1);
  assign m_axi_arsize   = size_q;
  assign m_axi_arburst  = burst_q;
  assign m_axi_arlock   = lock_q;
  assign m_axi_arcache  = cache_q;
  assign m_axi_arprot   = prot_q;
  assign m_axi_arqos    = qos_q;
  assign m_axi_arregion = region_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (s_ar_hs) state_nxt = SPLIT;
      SPLIT: if (m_ar_hs && sub == remaining_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      id_q        <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      lock_q      <= '0;
      cache_q     <= '0;
      prot_q      <= '0;
      qos_q       <= '0;
      region_q    <= '0;
    end else if (s_ar_hs) begin
      addr_q      <= s_axi_araddr;
      id_q        <= s_axi_arid;
      remaining_q <= {1'b0, s_axi_arlen} + 9'd1;
      size_q      <= s_axi_arsize;
      burst_q     <= s_axi_arburst;
      lock_q      <= s_axi_arlock;
      cache_q     <= s_axi_arcache;
      prot_q      <= s_axi_arprot;
      qos_q       <= s_axi_arqos;
      region_q    <= s_axi_arregion;
    end else if (m_ar_hs) begin
      remaining_q <= remaining_q - sub;
      addr_q      <= (addr_q & addr_mask) + addr_step;
    end
  end

  // A sub-burst issued and another retired in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) outstanding_q <= '0;
    else begin
      case ({m_ar_hs, r_last_hs})
        2'b10:   outstanding_q <= outstanding_q + 8'd1;
        2'b01:   outstanding_q <= outstanding_q - 8'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

`ifdef VX_AXI_SPLIT_RSP_BUF_EN
  localparam int RW = AXI_DATA_WIDTH + 2 + 1 + AXI_TID_WIDTH;

  logic [RW-1:0] buf_mem [2];
  logic          wr_ptr, rd_ptr, push, pop;
  logic [1:0]    count;

  assign m_axi_rready = (count != 2'd2);
  assign s_axi_rvalid = (count != 2'd0);
  assign push = m_axi_rvalid && m_axi_rready;
  assign pop  = s_axi_rvalid && s_axi_rready;
  assign {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid} = buf_mem[rd_ptr];

  // Entries hold the already-stripped rlast and the narrowed ID.
  always_ff @(posedge clk) begin
    if (push)
      buf_mem[wr_ptr] <= {m_axi_rdata, m_axi_rresp, m_axi_rlast & m_axi_rid[AXI_TID_WIDTH],
                          m_axi_rid[AXI_TID_WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
`else
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast & m_axi_rid[AXI_TID_WIDTH];
  assign s_axi_rid    = m_axi_rid[AXI_TID_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_vx_axi_read_burst_splitter.sv
// Directed bench for vx_axi_read_burst_splitter with a scripted downstream slave (MAX_OUTSTANDING=2).
module tb_vx_axi_read_burst_splitter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n;
  initial forever #5 clk = ~clk;

  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr;
  logic [7:0] s_arid, s_arlen, s_rid;
  logic [2:0] s_arsize, s_arprot;
  logic [1:0] s_arburst, s_arlock, s_rresp;
  logic [3:0] s_arcache, s_arqos, s_arregion;
  logic [DW-1:0] s_rdata;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr;
  logic [8:0] m_arid, m_rid;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize, m_arprot;
  logic [1:0] m_arburst, m_arlock, m_rresp;
  logic [3:0] m_arcache, m_arqos, m_arregion;
  logic [DW-1:0] m_rdata;

  vx_axi_read_burst_splitter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(32), .AXI_TID_WIDTH(8),
                               .MAX_BURST_LEN(16), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_araddr(s_araddr), .s_axi_arid(s_arid),
    .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
    .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos), .s_axi_arregion(s_arregion),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
    .s_axi_rlast(s_rlast), .s_axi_rid(s_rid),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr), .m_axi_arid(m_arid),
    .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
    .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos), .m_axi_arregion(m_arregion),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .m_axi_rlast(m_rlast), .m_axi_rid(m_rid)
  );

  int checks = 0, passes = 0, cyc = 0;
  initial forever @(posedge clk) cyc++;

  // Downstream AR log and R-beat scoreboard.
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [8:0]  ar_id_q[$];
  logic [2:0]  ar_size_q[$];
  logic [1:0]  ar_burst_q[$];
  logic [16:0] ar_sb_q[$];
  int          ar_cyc_q[$], rl_cyc_q[$];
  logic [DW-1:0] rx_data[$];
  logic [1:0]  rx_resp[$];
  logic        rx_last[$];
  logic [7:0]  rx_id[$];

  // Slave controls: ar_cfg 0=never ready, 1=always ready, 2=ready only while presenting an rlast beat.
  int  ar_cfg = 1;
  bit  r_en = 0, slave_flush = 0, rr_toggle = 0;
  int  ar_total = 0, rl_total = 0, max_out = 0, bidx = 0;
  int  rready_err = 0, full_seen = 0, occ = 0;
  logic [DW-1:0] data_ctr = 0;
  logic [7:0] rq_len[$];
  logic [8:0] rq_id[$];

  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
    forever begin
      @(negedge clk);
      if (m_arvalid && m_arready) begin
        ar_addr_q.push_back(m_araddr); ar_len_q.push_back(m_arlen); ar_id_q.push_back(m_arid);
        ar_size_q.push_back(m_arsize); ar_burst_q.push_back(m_arburst); ar_cyc_q.push_back(cyc);
        ar_sb_q.push_back({m_arlock, m_arcache, m_arprot, m_arqos, m_arregion});
        rq_len.push_back(m_arlen); rq_id.push_back(m_arid); ar_total++;
      end
      if (m_rvalid && m_rready) begin
        data_ctr = data_ctr + 1;
        if (m_rlast) begin
          void'(rq_len.pop_front()); void'(rq_id.pop_front());
          bidx = 0; rl_total++; rl_cyc_q.push_back(cyc);
        end else bidx++;
      end
      if (ar_total - rl_total > max_out) max_out = ar_total - rl_total;
      @(posedge clk); #2;
      if (slave_flush) begin
        rq_len.delete(); rq_id.delete(); bidx = 0; ar_total = 0; rl_total = 0;
      end
      if (r_en && !slave_flush && rq_len.size() > 0) begin
        m_rvalid = 1; m_rdata = data_ctr; m_rresp = data_ctr[1:0]; m_rid = rq_id[0];
        m_rlast = (bidx == int'(rq_len[0]));
      end else begin
        m_rvalid = 0; m_rlast = 0;
      end
      m_arready = (ar_cfg == 1) || (ar_cfg == 2 && m_rvalid && m_rlast);
    end
  end

  initial begin
    s_rready = 1;
    forever begin
      @(posedge clk); #1;
      s_rready = rr_toggle ? !s_rready : 1'b1;
    end
  end

  // Upstream R monitor, plus m_axi_rready tracking against the expected buffer occupancy.
  initial forever begin
    @(negedge clk);
    if (s_rvalid && s_rready) begin
      rx_data.push_back(s_rdata); rx_resp.push_back(s_rresp); rx_last.push_back(s_rlast); rx_id.push_back(s_rid);
    end
`ifdef VX_AXI_SPLIT_RSP_BUF_EN
    if (!reset_n) occ = 0;
    if (m_rready !== (occ < 2)) rready_err++;
    if (occ == 2) full_seen++;
    occ = occ + ((m_rvalid && m_rready) ? 1 : 0) - ((s_rvalid && s_rready) ? 1 : 0);
`else
    if (m_rready !== s_rready) rready_err++;
`endif
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); ar_id_q.delete(); ar_size_q.delete(); ar_burst_q.delete();
    ar_sb_q.delete(); ar_cyc_q.delete(); rl_cyc_q.delete();
    rx_data.delete(); rx_resp.delete(); rx_last.delete(); rx_id.delete();
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [7:0] id, output bit ok, output int hs_cyc);
    @(posedge clk); #1;
    s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bu; s_arid = id; s_arvalid = 1;
    ok = 0; hs_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_arready) begin ok = 1; hs_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    s_arvalid = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_data.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_ar(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ar_addr_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic rx_scan(input logic [7:0] id, output int lasts, output int last_idx, output int bad);
    lasts = 0; last_idx = 0; bad = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_last[i]) begin lasts++; last_idx = i + 1; end
      if (rx_id[i] !== id) bad++;
      if (rx_resp[i] !== rx_data[i][1:0]) bad++;
      if (i > 0 && rx_data[i] !== rx_data[i-1] + 1) bad++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_arready !== 1'b0) $display("FAIL reset_arready: got %b want 0", s_arready); else passes++;
    checks++; if (m_arvalid !== 1'b0) $display("FAIL reset_m_arvalid: got %b want 0", m_arvalid); else passes++;
    checks++; if (s_rvalid !== 1'b0) $display("FAIL reset_s_rvalid: got %b want 0", s_rvalid); else passes++;
    @(posedge clk); #1; reset_n = 1;
    @(negedge clk);
    checks++; if (s_arready !== 1'b1) $display("FAIL release_arready: got %b want 1", s_arready); else passes++;
  endtask

  task automatic test_split_incr();
    bit ok; int hc, lasts, li, bad;
    logic [31:0] ea[3]; logic [7:0] el[3]; logic [8:0] ei[3];
    ea = '{32'h1000, 32'h1400, 32'h1800}; el = '{8'd15, 8'd15, 8'd7}; ei = '{9'h005, 9'h005, 9'h105};
    clear_logs(); ar_cfg = 1; r_en = 1;
    s_arlock = 2'd1; s_arcache = 4'hA; s_arprot = 3'h5; s_arqos = 4'h3; s_arregion = 4'hC;
    send_ar(32'h1000, 8'd39, 3'd6, 2'b01, 8'h05, ok, hc);
    checks++; if (!ok) $display("FAIL split_ar_accept: upstream handshake timed out"); else passes++;
    wait_rx(40, 2000, ok);
    checks++; if (!ok) $display("FAIL split_rx_timeout: got %0d beats want 40", rx_data.size()); else passes++;
    checks++; if (ar_addr_q.size() != 3) $display("FAIL split_ar_count: got %0d want 3", ar_addr_q.size()); else passes++;
    for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
      checks++; if (ar_addr_q[i] !== ea[i]) $display("FAIL split_addr%0d: got %h want %h", i, ar_addr_q[i], ea[i]); else passes++;
      checks++; if (ar_len_q[i] !== el[i]) $display("FAIL split_len%0d: got %0d want %0d", i, ar_len_q[i], el[i]); else passes++;
      checks++; if (ar_id_q[i] !== ei[i]) $display("FAIL split_id%0d: got %h want %h", i, ar_id_q[i], ei[i]); else passes++;
    end
    if (ar_addr_q.size() == 3) begin
      checks++; if (ar_cyc_q[0] != hc + 1) $display("FAIL split_ar_latency: got %0d want %0d", ar_cyc_q[0] - hc, 1); else passes++;
      checks++; if (ar_size_q[2] !== 3'd6 || ar_burst_q[2] !== 2'b01)
        $display("FAIL split_shape: got size %0d burst %0d want 6 1", ar_size_q[2], ar_burst_q[2]); else passes++;
      checks++; if (ar_sb_q[2] !== {2'd1, 4'hA, 3'h5, 4'h3, 4'hC})
        $display("FAIL split_sideband: got %h want %h", ar_sb_q[2], {2'd1, 4'hA, 3'h5, 4'h3, 4'hC}); else passes++;
    end
    rx_scan(8'h05, lasts, li, bad);
    checks++; if (lasts != 1 || li != 40) $display("FAIL split_rlast: got %0d lasts at %0d want 1 at 40", lasts, li); else passes++;
    checks++; if (bad != 0) $display("FAIL split_rbeats: got %0d bad beats want 0", bad); else passes++;
  endtask

  task automatic test_unaligned();
    bit ok; int hc, lasts, li, bad;
    clear_logs();
    send_ar(32'h1010, 8'd16, 3'd6, 2'b01, 8'h0A, ok, hc);
    wait_rx(17, 1000, ok);
    checks++; if (!ok) $display("FAIL unal_rx_timeout: got %0d beats want 17", rx_data.size()); else passes++;
    checks++; if (ar_addr_q.size() != 2) $display("FAIL unal_ar_count: got %0d want 2", ar_addr_q.size()); else passes++;
    if (ar_addr_q.size() == 2) begin
      checks++; if (ar_addr_q[0] !== 32'h1010 || ar_len_q[0] !== 8'd15 || ar_id_q[0] !== 9'h00A)
        $display("FAIL unal_ar0: got %h/%0d/%h want 1010/15/00a", ar_addr_q[0], ar_len_q[0], ar_id_q[0]); else passes++;
      checks++; if (ar_addr_q[1] !== 32'h1400 || ar_len_q[1] !== 8'd0 || ar_id_q[1] !== 9'h10A)
        $display("FAIL unal_ar1: got %h/%0d/%h want 1400/0/10a", ar_addr_q[1], ar_len_q[1], ar_id_q[1]); else passes++;
    end
    rx_scan(8'h0A, lasts, li, bad);
    checks++; if (lasts != 1 || li != 17 || bad != 0)
      $display("FAIL unal_rx: got %0d lasts at %0d bad %0d want 1 at 17 bad 0", lasts, li, bad); else passes++;
  endtask

  task automatic test_fixed_wrap();
    bit ok; int hc, lasts, li, bad;
    clear_logs();
    send_ar(32'h2000, 8'd31, 3'd2, 2'b00, 8'h33, ok, hc);
    wait_rx(32, 1000, ok);
    checks++; if (!ok) $display("FAIL fixed_rx_timeout: got %0d beats want 32", rx_data.size()); else passes++;
    checks++; if (ar_addr_q.size() != 1) $display("FAIL fixed_ar_count: got %0d want 1", ar_addr_q.size()); else passes++;
    if (ar_addr_q.size() == 1) begin
      checks++; if (ar_addr_q[0] !== 32'h2000 || ar_len_q[0] !== 8'd31 || ar_id_q[0] !== 9'h133)
        $display("FAIL fixed_ar: got %h/%0d/%h want 2000/31/133", ar_addr_q[0], ar_len_q[0], ar_id_q[0]); else passes++;
    end
    rx_scan(8'h33, lasts, li, bad);
    checks++; if (lasts != 1 || li != 32 || bad != 0)
      $display("FAIL fixed_rx: got %0d lasts at %0d bad %0d want 1 at 32 bad 0", lasts, li, bad); else passes++;
    clear_logs();
    send_ar(32'h3000, 8'd7, 3'd2, 2'b10, 8'h44, ok, hc);
    wait_rx(8, 500, ok);
    checks++; if (ar_addr_q.size() != 1 || ar_len_q[0] !== 8'd7 || ar_id_q[0] !== 9'h144 || ar_addr_q[0] !== 32'h3000)
      $display("FAIL wrap_ar: got %0d ARs, first len %0d id %h want 1 AR len 7 id 144", ar_addr_q.size(), ar_len_q[0], ar_id_q[0]);
    else passes++;
  endtask

  task automatic test_rbuf_backpressure();
    bit ok; int hc, lasts, li, bad;
    clear_logs(); rready_err = 0; full_seen = 0;
    @(posedge clk); #1; rr_toggle = 1;
    send_ar(32'h4000, 8'd39, 3'd6, 2'b01, 8'h21, ok, hc);
    wait_rx(40, 3000, ok);
    checks++; if (!ok) $display("FAIL bp_rx_timeout: got %0d beats want 40", rx_data.size()); else passes++;
    repeat (10) @(negedge clk);
    checks++; if (rx_data.size() != 40) $display("FAIL bp_beat_count: got %0d want 40", rx_data.size()); else passes++;
    rx_scan(8'h21, lasts, li, bad);
    checks++; if (lasts != 1 || li != 40 || bad != 0)
      $display("FAIL bp_rx: got %0d lasts at %0d bad %0d want 1 at 40 bad 0", lasts, li, bad); else passes++;
    checks++; if (rready_err != 0) $display("FAIL bp_m_rready: got %0d wrong cycles want 0", rready_err); else passes++;
`ifdef VX_AXI_SPLIT_RSP_BUF_EN
    checks++; if (full_seen == 0) $display("FAIL bp_buffer_full: got %0d full cycles want >0", full_seen); else passes++;
`endif
    @(posedge clk); #1; rr_toggle = 0;
  endtask

  task automatic test_credit();
    bit ok; int hc, lasts, li, bad;
    clear_logs(); ar_cfg = 1; r_en = 0; max_out = 0;
    send_ar(32'h0, 8'd79, 3'd6, 2'b01, 8'h07, ok, hc);
    repeat (6) @(negedge clk);
    checks++; if (ar_addr_q.size() != 2) $display("FAIL credit_ar_cap: got %0d want 2", ar_addr_q.size()); else passes++;
    checks++; if (m_arvalid !== 1'b0) $display("FAIL credit_arvalid_low: got %b want 0", m_arvalid); else passes++;
    @(posedge clk); #1; r_en = 1;
    wait_ar(3, 200, ok);
    checks++; if (!ok || rl_cyc_q.size() < 1) $display("FAIL credit_third_ar: got %0d ARs want 3", ar_addr_q.size());
    else if (ar_cyc_q[2] != rl_cyc_q[0] + 1)
      $display("FAIL credit_third_ar: got delay %0d want 1", ar_cyc_q[2] - rl_cyc_q[0]);
    else passes++;
    @(posedge clk); #1; ar_cfg = 2;
    wait_rx(80, 3000, ok);
    checks++; if (!ok) $display("FAIL credit_rx_timeout: got %0d beats want 80", rx_data.size()); else passes++;
    checks++; if (ar_addr_q.size() != 5) $display("FAIL credit_ar_total: got %0d want 5", ar_addr_q.size()); else passes++;
    if (ar_addr_q.size() == 5 && rl_cyc_q.size() >= 4) begin
      checks++; if (ar_cyc_q[3] != rl_cyc_q[2] || ar_cyc_q[4] != rl_cyc_q[3])
        $display("FAIL credit_simultaneous: got AR cycles %0d %0d want %0d %0d", ar_cyc_q[3], ar_cyc_q[4], rl_cyc_q[2], rl_cyc_q[3]);
      else passes++;
      checks++; if (ar_addr_q[4] !== 32'h1000 || ar_id_q[4] !== 9'h107 || ar_len_q[4] !== 8'd15)
        $display("FAIL credit_last_ar: got %h/%h/%0d want 1000/107/15", ar_addr_q[4], ar_id_q[4], ar_len_q[4]); else passes++;
    end
    checks++; if (max_out > 2) $display("FAIL credit_max_outstanding: got %0d want <=2", max_out); else passes++;
    rx_scan(8'h07, lasts, li, bad);
    checks++; if (lasts != 1 || li != 80 || bad != 0)
      $display("FAIL credit_rx: got %0d lasts at %0d bad %0d want 1 at 80 bad 0", lasts, li, bad); else passes++;
    ar_cfg = 1;
  endtask

  task automatic test_reset_mid_split();
    bit ok; int hc, lasts, li, bad;
    clear_logs(); ar_cfg = 1; r_en = 0;
    send_ar(32'h8000, 8'd63, 3'd6, 2'b01, 8'h55, ok, hc);
    wait_ar(1, 50, ok);
    @(posedge clk); #1; reset_n = 0; slave_flush = 1;
    #1;
    checks++; if (m_arvalid !== 1'b0) $display("FAIL rst_mid_arvalid: got %b want 0", m_arvalid); else passes++;
    checks++; if (s_arready !== 1'b0 || s_rvalid !== 1'b0)
      $display("FAIL rst_mid_outputs: got arready %b rvalid %b want 0 0", s_arready, s_rvalid); else passes++;
    repeat (2) @(posedge clk);
    #1; reset_n = 1; slave_flush = 0; clear_logs();
    @(negedge clk);
    checks++; if (s_arready !== 1'b1 || m_arvalid !== 1'b0)
      $display("FAIL rst_mid_idle: got arready %b arvalid %b want 1 0", s_arready, m_arvalid); else passes++;
    send_ar(32'h9000, 8'd31, 3'd6, 2'b01, 8'h66, ok, hc);
    repeat (6) @(negedge clk);
    checks++; if (ar_addr_q.size() != 2) $display("FAIL rst_mid_credit_clear: got %0d ARs want 2", ar_addr_q.size()); else passes++;
    if (ar_addr_q.size() >= 1) begin
      checks++; if (ar_addr_q[0] !== 32'h9000 || ar_id_q[0] !== 9'h066)
        $display("FAIL rst_mid_new_ar: got %h/%h want 9000/066", ar_addr_q[0], ar_id_q[0]); else passes++;
    end
    @(posedge clk); #1; r_en = 1;
    wait_rx(32, 1000, ok);
    rx_scan(8'h66, lasts, li, bad);
    checks++; if (!ok || lasts != 1 || li != 32 || bad != 0)
      $display("FAIL rst_mid_rx: got %0d beats %0d lasts at %0d bad %0d want 32 1 at 32 bad 0", rx_data.size(), lasts, li, bad);
    else passes++;
  endtask

  initial begin
    reset_n = 0;
    s_arvalid = 0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arlock = '0; s_arcache = '0; s_arprot = '0; s_arqos = '0; s_arregion = '0;
    test_reset();
    test_split_incr();
    test_unaligned();
    test_fixed_wrap();
    test_rbuf_backpressure();
    test_credit();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
